// File: rtl/spm_driver.sv
// rtl/spm_driver.sv - sequencer that feeds a serial-parallel multiplier and assembles its product
module spm_driver #(
    parameter int WIDTH = 32,
    parameter int P_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_y,
    output logic [WIDTH-1:0]     spm_x,
    output logic                 spm_y,
    output logic                 spm_clr,
    input  logic                 spm_p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p
);

    localparam int N  = 2 * WIDTH + P_LAT;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] LAT  = CW'(P_LAT);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] y_sr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = CLEAR;
            CLEAR:   state_nx = SHIFT;
            SHIFT:   if (cnt == LAST) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // spm_y is registered, so the bit for the next SHIFT cycle is launched one edge early.
    always_ff @(posedge clk) begin
        if (!rst) begin
            spm_x   <= '0;
            spm_y   <= 1'b0;
            spm_clr <= 1'b0;
            out_p   <= '0;
            cnt     <= '0;
            y_sr    <= '0;
        end else begin
            spm_clr <= (state == IDLE) && in_valid;
            spm_y   <= (state_nx == SHIFT) ? y_sr[0] : 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        spm_x <= in_x;
                        y_sr  <= in_y;
                        out_p <= '0;
                    end
                end
                CLEAR: begin
                    cnt  <= '0;
                    y_sr <= y_sr >> 1;
                end
                SHIFT: begin
                    y_sr <= y_sr >> 1;
                    if (cnt != LAST) cnt <= cnt + CW'(1);
                    // The first P_LAT product bits are still in the spm pipeline.
                    if (cnt >= LAT) out_p <= {spm_p, out_p[2*WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spm_driver.sv
// tb/tb_spm_driver.sv - directed and random bench for spm_driver with a behavioural spm
module tb_spm_driver;

    localparam int WIDTH = 8;
    localparam int P_LAT = 1;
    localparam int N     = 2 * WIDTH + P_LAT;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   in_x = '0;
    logic [WIDTH-1:0]   in_y = '0;
    logic [WIDTH-1:0]   spm_x;
    logic               spm_y;
    logic               spm_clr;
    logic               spm_p;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [2*WIDTH-1:0] out_p;

    int checks = 0;
    int passes = 0;

    spm_driver #(.WIDTH(WIDTH), .P_LAT(P_LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .spm_x(spm_x), .spm_y(spm_y),
        .spm_clr(spm_clr), .spm_p(spm_p), .out_valid(out_valid),
        .out_ready(out_ready), .out_p(out_p)
    );

    always #5 clk = ~clk;

    // Behavioural spm: accumulate x<<j for each serial y bit, emit bit j after one cycle.
    logic [31:0] acc = '0;
    logic [31:0] sum;
    int          j = 0;
    logic        p_pipe = 1'b0;

    always_comb begin
        sum = acc + (spm_y ? ({24'b0, spm_x} << j) : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (spm_clr) begin
            acc    <= '0;
            j      <= 0;
            p_pipe <= 1'b0;
        end else begin
            acc    <= sum;
            p_pipe <= sum[j];
            if (j < 31) j <= j + 1;
        end
    end

    assign spm_p = p_pipe;

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic start_op(input logic [7:0] x, input logic [7:0] y, input bit noise,
                            output int lat);
        int guard;
        in_x = x;
        in_y = y;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_x = ~x;
        in_y = ~y;
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (noise) begin
                in_valid  = 1'($urandom);
                out_ready = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        in_x = 8'hAA;
        in_y = 8'h55;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passes++;
        checks++; if (out_p !== 16'h0) $display("FAIL reset_out_p got %h want 0000", out_p); else passes++;
        checks++; if ({spm_x, spm_y, spm_clr} !== 10'h0)
            $display("FAIL reset_spm got x=%h y=%b clr=%b want 0", spm_x, spm_y, spm_clr); else passes++;
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        in_x = 8'd5;
        in_y = 8'd3;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready_drop got %b want 0", in_ready); else passes++;
        checks++; if ({spm_clr, spm_y} !== 2'b10) $display("FAIL basic_clear got clr=%b y=%b want 1/0", spm_clr, spm_y); else passes++;
        checks++; if (spm_x !== 8'd5) $display("FAIL basic_spm_x got %h want 05", spm_x); else passes++;
        @(negedge clk);
        lat = 2;
        checks++; if ({spm_clr, spm_y} !== 2'b01) $display("FAIL basic_shift0 got clr=%b y=%b want 0/1", spm_clr, spm_y); else passes++;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 19) $display("FAIL basic_latency got %0d want 19", lat); else passes++;
        checks++; if (out_p !== 16'h000F) $display("FAIL basic_product got %h want 000f", out_p); else passes++;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL basic_return_idle got v=%b r=%b want 0/1", out_valid, in_ready); else passes++;
    endtask

    task automatic test_full_scale();
        logic [N-1:0] seq;
        in_x = 8'hFF;
        in_y = 8'hFF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            seq[c] = spm_y;
        end
        checks++; if (seq !== 17'h000FF) $display("FAIL full_spm_y_seq got %h want 000ff", seq); else passes++;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) $display("FAIL full_valid got %b want 1", out_valid); else passes++;
        checks++; if (out_p !== 16'hFE01) $display("FAIL full_product got %h want fe01", out_p); else passes++;
        consume();
    endtask

    task automatic test_zero();
        int lat;
        start_op(8'hA5, 8'h00, 1'b0, lat);
        checks++; if (out_p !== 16'h0 || !out_valid) $display("FAIL zero_y got %h v=%b want 0000", out_p, out_valid); else passes++;
        consume();
        start_op(8'h00, 8'h5A, 1'b0, lat);
        checks++; if (out_p !== 16'h0 || lat !== 19) $display("FAIL zero_x got %h lat=%0d want 0000 lat=19", out_p, lat); else passes++;
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        start_op(8'h12, 8'h34, 1'b0, lat);
        checks++; if (out_p !== 16'h03A8) $display("FAIL b2b_first got %h want 03a8", out_p); else passes++;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_x = 8'hC3;
            in_y = 8'h3C;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_p !== 16'h03A8 || in_ready !== 1'b0)
                $display("FAIL b2b_hold%0d got v=%b p=%h r=%b want 1/03a8/0", i, out_valid, out_p, in_ready);
            else passes++;
        end
        in_valid = 1'b0;
        consume();
        start_op(8'h80, 8'h02, 1'b0, lat);
        checks++; if (out_p !== 16'h0100 || lat !== 19) $display("FAIL b2b_second got %h lat=%0d want 0100 lat=19", out_p, lat); else passes++;
        consume();
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        in_x = 8'h33;
        in_y = 8'h44;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== 16'h0 || spm_x !== 8'h0 || spm_y !== 1'b0)
            $display("FAIL mid_reset got r=%b v=%b p=%h x=%h y=%b want 1/0/0000/00/0", in_ready, out_valid, out_p, spm_x, spm_y);
        else passes++;
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL mid_no_valid got %0d valid cycles want 0", seen); else passes++;
        start_op(8'd7, 8'd9, 1'b0, lat);
        checks++; if (out_p !== 16'h003F) $display("FAIL mid_after got %h want 003f", out_p); else passes++;
        consume();
    endtask

    task automatic test_random();
        int lat;
        int bad;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] want;
        logic [15:0] got;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) begin
                in_x = 8'($urandom);
                @(negedge clk);
            end
            x = 8'($urandom);
            y = 8'($urandom);
            want = 16'(x) * 16'(y);
            start_op(x, y, 1'b1, lat);
            got = out_p;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                if (out_p !== got) bad++;
            end
            consume();
            checks++;
            if (got !== want || lat !== 19 || bad != 0 || out_valid !== 1'b0)
                $display("FAIL random%0d got %h lat=%0d unstable=%0d v_after=%b want %h lat=19", i, got, lat, bad, out_valid, want);
            else passes++;
            bad = 0;
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_full_scale();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
